// File: rtl/coeff_dequant_writer.sv
// coeff_dequant_writer: takes the zigzag-ordered quantized coefficient stream,
// dequantizes each value by a power-of-two shift and writes it into the
// pre-IDCT SRAM region in the block/row layout the IDCT fetch stage reads.
// Optional build macro: DEQUANT_SATURATE_EN (saturate to 16-bit signed
// instead of keeping the low 16 bits).
//
// Handshake: a coefficient is consumed on a rising edge where
// in_valid && in_ready; in_ready is high only in RUN. The matching SRAM write
// (SRAM_we_n=0 with registered address/data) appears in the very next cycle.
module coeff_dequant_writer #(
  parameter int PREIDCT_BASE = 76800,
  parameter int Y_WIDTH      = 320,
  parameter int UV_WIDTH     = 160,
  parameter int IMG_ROWS     = 240
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Q_sel,
  input  logic        in_valid,
  input  logic [15:0] in_coeff,
  input  logic        in_eob,
  output logic        in_ready,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  dbg_state
);

  localparam int Y_COLS  = Y_WIDTH / 8;
  localparam int UV_COLS = UV_WIDTH / 8;
  localparam int BROWS   = IMG_ROWS / 8;
  localparam int N_BLK   = BROWS * (Y_COLS + 2 * UV_COLS);

  localparam logic [17:0] Y_BASE   = 18'(PREIDCT_BASE);
  localparam logic [17:0] U_BASE   = 18'(PREIDCT_BASE + Y_WIDTH * IMG_ROWS);
  localparam logic [17:0] V_BASE   = 18'(PREIDCT_BASE + Y_WIDTH * IMG_ROWS + UV_WIDTH * IMG_ROWS);
  localparam logic [17:0] Y_PITCH  = 18'(Y_WIDTH);
  localparam logic [17:0] UV_PITCH = 18'(UV_WIDTH);
  localparam logic [7:0]  Y_COLS_M1  = 8'(Y_COLS - 1);
  localparam logic [7:0]  UV_COLS_M1 = 8'(UV_COLS - 1);
  localparam logic [7:0]  BROWS_M1   = 8'(BROWS - 1);
  localparam logic [11:0] LAST_BLK   = 12'(N_BLK - 1);

  typedef enum logic [1:0] {IDLE, RUN, FILL, FINISH} state_t;

  state_t      state, state_nxt;
  logic [5:0]  k;        // zigzag index within the block
  logic [11:0] blk;      // block number within the frame
  logic [1:0]  seg;      // 0=Y, 1=U, 2=V
  logic [7:0]  brow;     // block row within the segment
  logic [7:0]  bcol;     // block column within the segment
  logic        q_lat;

  logic        step, k_last, blk_last;
  logic [5:0]  pos;
  logic [2:0]  r, c, shamt;
  logic [3:0]  s;
  logic [17:0] seg_base, pitch, row18, addr_calc;
  logic [7:0]  cols_m1;
  logic [15:0] deq;

  // Zigzag index -> raster position (row*8 + col) within the 8x8 block.
  function automatic logic [5:0] zz_pos(input logic [5:0] idx);
    logic [5:0] p;
    p = 6'd0;
    case (idx)
      6'd0:  p = 6'd0;  6'd1:  p = 6'd1;  6'd2:  p = 6'd8;  6'd3:  p = 6'd16;
      6'd4:  p = 6'd9;  6'd5:  p = 6'd2;  6'd6:  p = 6'd3;  6'd7:  p = 6'd10;
      6'd8:  p = 6'd17; 6'd9:  p = 6'd24; 6'd10: p = 6'd32; 6'd11: p = 6'd25;
      6'd12: p = 6'd18; 6'd13: p = 6'd11; 6'd14: p = 6'd4;  6'd15: p = 6'd5;
      6'd16: p = 6'd12; 6'd17: p = 6'd19; 6'd18: p = 6'd26; 6'd19: p = 6'd33;
      6'd20: p = 6'd40; 6'd21: p = 6'd48; 6'd22: p = 6'd41; 6'd23: p = 6'd34;
      6'd24: p = 6'd27; 6'd25: p = 6'd20; 6'd26: p = 6'd13; 6'd27: p = 6'd6;
      6'd28: p = 6'd7;  6'd29: p = 6'd14; 6'd30: p = 6'd21; 6'd31: p = 6'd28;
      6'd32: p = 6'd35; 6'd33: p = 6'd42; 6'd34: p = 6'd49; 6'd35: p = 6'd56;
      6'd36: p = 6'd57; 6'd37: p = 6'd50; 6'd38: p = 6'd43; 6'd39: p = 6'd36;
      6'd40: p = 6'd29; 6'd41: p = 6'd22; 6'd42: p = 6'd15; 6'd43: p = 6'd23;
      6'd44: p = 6'd30; 6'd45: p = 6'd37; 6'd46: p = 6'd44; 6'd47: p = 6'd51;
      6'd48: p = 6'd58; 6'd49: p = 6'd59; 6'd50: p = 6'd52; 6'd51: p = 6'd45;
      6'd52: p = 6'd38; 6'd53: p = 6'd31; 6'd54: p = 6'd39; 6'd55: p = 6'd46;
      6'd56: p = 6'd53; 6'd57: p = 6'd60; 6'd58: p = 6'd61; 6'd59: p = 6'd54;
      6'd60: p = 6'd47; 6'd61: p = 6'd55; 6'd62: p = 6'd62; 6'd63: p = 6'd63;
      default: p = 6'd0;
    endcase
    return p;
  endfunction

  assign in_ready  = (state == RUN);
  assign Busy      = (state != IDLE);
  assign dbg_state = state;
  assign step      = ((state == RUN) && in_valid) || (state == FILL);
  assign k_last    = (k == 6'd63);
  assign blk_last  = (blk == LAST_BLK);
  assign pos       = zz_pos(k);
  assign r         = pos[5:3];
  assign c         = pos[2:0];
  assign s         = {1'b0, r} + {1'b0, c};

  // Segment base, pitch and blocks-per-row for the current block.
  always_comb begin
    seg_base = Y_BASE;
    pitch    = Y_PITCH;
    cols_m1  = Y_COLS_M1;
    case (seg)
      2'd1:    begin seg_base = U_BASE; pitch = UV_PITCH; cols_m1 = UV_COLS_M1; end
      2'd2:    begin seg_base = V_BASE; pitch = UV_PITCH; cols_m1 = UV_COLS_M1; end
      default: begin seg_base = Y_BASE; pitch = Y_PITCH;  cols_m1 = Y_COLS_M1;  end
    endcase
  end

  // Write address: base + (brow*8 + r)*pitch + bcol*8 + c.
  always_comb begin
    row18     = 18'({brow, 3'b000}) + 18'(r);
    addr_calc = seg_base + row18 * pitch + 18'({bcol, 3'b000}) + 18'(c);
  end

  // Shift amount from the frequency sum r+c and the latched matrix select.
  always_comb begin
    shamt = 3'd3;
    if (!q_lat) begin
      case (s)
        4'd0: shamt = 3'd3; 4'd1: shamt = 3'd2; 4'd2: shamt = 3'd3; 4'd3: shamt = 3'd3;
        4'd4: shamt = 3'd4; 4'd5: shamt = 3'd4;
        default: shamt = 3'd5;
      endcase
    end else begin
      case (s)
        4'd0: shamt = 3'd3; 4'd1: shamt = 3'd1; 4'd2: shamt = 3'd1; 4'd3: shamt = 3'd1;
        4'd4: shamt = 3'd2; 4'd5: shamt = 3'd2;
        default: shamt = 3'd3;
      endcase
    end
  end

`ifdef DEQUANT_SATURATE_EN
  logic signed [23:0] wide;
  // 24-bit signed shift, then clamp into the 16-bit signed range.
  always_comb begin
    wide = $signed({{8{in_coeff[15]}}, in_coeff}) <<< shamt;
    if (wide > 24'sd32767)       deq = 16'h7FFF;
    else if (wide < -24'sd32768) deq = 16'h8000;
    else                         deq = wide[15:0];
  end
`else
  // Wraparound: the low 16 bits of the 24-bit product equal a 16-bit shift.
  always_comb begin
    deq = in_coeff << shamt;
  end
`endif

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (Start) state_nxt = RUN;
      RUN: begin
        if (in_valid) begin
          if (k_last) begin
            if (blk_last) state_nxt = FINISH;
          end else if (in_eob) begin
            state_nxt = FILL;
          end
        end
      end
      FILL:   if (k_last) state_nxt = blk_last ? FINISH : RUN;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters and registered SRAM write port.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      k               <= 6'd0;
      blk             <= 12'd0;
      seg             <= 2'd0;
      brow            <= 8'd0;
      bcol            <= 8'd0;
      q_lat           <= 1'b0;
      SRAM_we_n       <= 1'b1;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      Done            <= 1'b0;
    end else begin
      SRAM_we_n <= 1'b1;
      Done      <= (state == FINISH);
      if ((state == IDLE) && Start) begin
        k     <= 6'd0;
        blk   <= 12'd0;
        seg   <= 2'd0;
        brow  <= 8'd0;
        bcol  <= 8'd0;
        q_lat <= Q_sel;
      end
      if (step) begin
        SRAM_we_n       <= 1'b0;
        SRAM_address    <= addr_calc;
        SRAM_write_data <= (state == FILL) ? 16'd0 : deq;
        if (k_last) begin
          k   <= 6'd0;
          blk <= blk + 12'd1;
          if (bcol == cols_m1) begin
            bcol <= 8'd0;
            if (brow == BROWS_M1) begin
              brow <= 8'd0;
              seg  <= seg + 2'd1;
            end else begin
              brow <= brow + 8'd1;
            end
          end else begin
            bcol <= bcol + 8'd1;
          end
        end else begin
          k <= k + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_coeff_dequant_writer.sv
// Bench for coeff_dequant_writer. Uses a reduced frame height (IMG_ROWS=16)
// so complete frames, segment changes and frame end fit in a short run.
module tb_coeff_dequant_writer;

  localparam int PB   = 76800;
  localparam int YW   = 320;
  localparam int UVW  = 160;
  localparam int ROWS = 16;
  localparam int BR   = ROWS / 8;
  localparam int YB   = (YW / 8) * BR;
  localparam int UB   = (UVW / 8) * BR;
  localparam int N_BLK = YB + 2 * UB;

`ifdef DEQUANT_SATURATE_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [15:0] SAT_EXP = 16'h8000;
`endif

  logic        Clock, Resetn, Start, Q_sel, in_valid, in_eob;
  logic [15:0] in_coeff;
  logic        in_ready, SRAM_we_n, Busy, Done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic [1:0]  dbg_state;

  coeff_dequant_writer #(.PREIDCT_BASE(PB), .Y_WIDTH(YW), .UV_WIDTH(UVW), .IMG_ROWS(ROWS)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Q_sel(Q_sel),
    .in_valid(in_valid), .in_coeff(in_coeff), .in_eob(in_eob), .in_ready(in_ready),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .Busy(Busy), .Done(Done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  int zr[64];
  int zc[64];
  int sh0[8] = '{3, 2, 3, 3, 4, 4, 5, 5};
  int sh1[8] = '{3, 1, 1, 1, 2, 2, 3, 3};

  // Zigzag built by walking anti-diagonals, alternating direction.
  task automatic build_zigzag();
    int idx;
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int rr = lo; rr <= hi; rr++) begin zr[idx] = rr; zc[idx] = s - rr; idx++; end
      end else begin
        for (int rr = hi; rr >= lo; rr--) begin zr[idx] = rr; zc[idx] = s - rr; idx++; end
      end
    end
  endtask

  function automatic int model_addr(int b, int kk);
    int base, pitch, rel, cols;
    if (b < YB) begin
      base = PB; pitch = YW; rel = b; cols = YW / 8;
    end else if (b < YB + UB) begin
      base = PB + YW * ROWS; pitch = UVW; rel = b - YB; cols = UVW / 8;
    end else begin
      base = PB + YW * ROWS + UVW * ROWS; pitch = UVW; rel = b - YB - UB; cols = UVW / 8;
    end
    return base + ((rel / cols) * 8 + zr[kk]) * pitch + (rel % cols) * 8 + zc[kk];
  endfunction

  function automatic logic [15:0] model_deq(logic [15:0] coeff, int kk, bit q);
    int s, sh, v;
    s = zr[kk] + zc[kk];
    if (s > 7) s = 7;
    sh = q ? sh1[s] : sh0[s];
    v = $signed(coeff) * (1 << sh);
`ifdef DEQUANT_SATURATE_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int          exp_cyc_q[$];
  int total = 0;
  int bad = 0;
  int mk, mblk;
  bit mq;
  int exp_done_cyc = -1;
  int done_cnt = 0;

  task automatic push(input logic [33:0] e, input int c);
    exp_q.push_back(e);
    exp_cyc_q.push_back(c);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // Every write must be expected, in order, in the exact cycle predicted.
  always @(negedge Clock) begin
    if (Resetn === 1'b1) begin
      if (SRAM_we_n === 1'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d", SRAM_address, SRAM_write_data, cyc);
        end else begin
          logic [33:0] e;
          int ec;
          e = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if ({SRAM_address, SRAM_write_data} !== e || cyc != ec) begin
            bad++;
            $display("FAIL write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                     SRAM_address, SRAM_write_data, cyc, e[33:16], e[15:0], ec);
          end
        end
      end
      if (Done === 1'b1) begin
        total++;
        done_cnt++;
        if (cyc != exp_done_cyc || Busy !== 1'b0) begin
          bad++;
          $display("FAIL done_timing cyc=%0d busy=%b st=%0d want cyc=%0d busy=0", cyc, Busy, dbg_state, exp_done_cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  task automatic start_frame(input bit q);
    Start = 1'b1; Q_sel = q;
    @(posedge Clock); #1;
    Start = 1'b0;
    mk = 0; mblk = 0; mq = q;
    exp_done_cyc = -1; done_cnt = 0;
    chk("busy_after_start", 32'(Busy), 32'd1);
  endtask

  task automatic busy_start();
    Start = 1'b1; Q_sel = ~mq;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic send(input logic [15:0] coeff, input bit eob, input bit use_tab,
                      input logic [17:0] t_addr, input logic [15:0] t_data);
    int w, n0, last_cyc;
    in_coeff = coeff; in_eob = eob; in_valid = 1'b1; w = 0;
    while (in_ready !== 1'b1 && w < 300) begin @(posedge Clock); #1; w++; end
    if (w >= 300) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%b want=1", in_ready);
      in_valid = 1'b0; in_eob = 1'b0;
      return;
    end
    @(posedge Clock); #1;
    in_valid = 1'b0; in_eob = 1'b0;
    n0 = cyc;
    if (use_tab) push({t_addr, t_data}, n0);
    else         push({18'(model_addr(mblk, mk)), model_deq(coeff, mk, mq)}, n0);
    last_cyc = n0;
    if (mk == 63) begin
      mk = 0; mblk++;
    end else if (eob) begin
      for (int j = mk + 1; j < 64; j++) push({18'(model_addr(mblk, j)), 16'h0000}, n0 + j - mk);
      last_cyc = n0 + 63 - mk;
      mk = 0; mblk++;
    end else begin
      mk++;
    end
    if (mblk == N_BLK) exp_done_cyc = last_cyc + 1;
  endtask

  function automatic logic [15:0] rand_coeff();
    int v;
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    v = int'($urandom_range(0, 127)) - 64;
    return 16'(v);
  endfunction

  // Random blocks until the frame is complete; one ignored Start mid-frame.
  task automatic rand_frame();
    bit did_bs;
    did_bs = 1'b0;
    while (mblk < N_BLK) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
      if (mblk == 50 && !did_bs) begin busy_start(); did_bs = 1'b1; end
      send(rand_coeff(), ($urandom_range(0, 15) == 0), 1'b0, 18'd0, 16'd0);
    end
  endtask

  task automatic end_checks();
    idle(70);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("queue_empty_end", 32'(exp_q.size()), 32'd0);
    chk("busy_end", 32'(Busy), 32'd0);
    chk("we_n_end", 32'(SRAM_we_n), 32'd1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] coeff;
    bit          eob;
    logic [17:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t tab[6];

  initial begin
    int cnt;
    tab[0] = '{16'd5,    1'b0, 18'd76800, 16'h0028};
    tab[1] = '{16'hFFFD, 1'b0, 18'd76801, 16'hFFF4};
    tab[2] = '{16'd1,    1'b1, 18'd77120, 16'h0004};
    tab[3] = '{16'd7,    1'b1, 18'd76808, 16'h0038};
    tab[4] = '{16'h1000, 1'b1, 18'd76800, SAT_EXP};
    tab[5] = '{16'hF000, 1'b0, 18'd76808, 16'h8000};

    build_zigzag();
    Resetn = 1'b0; Start = 1'b0; Q_sel = 1'b0;
    in_valid = 1'b0; in_coeff = 16'd0; in_eob = 1'b0;
    mk = 0; mblk = 0; mq = 1'b0;

    // Reset values.
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we_n", 32'(SRAM_we_n), 32'd1);
    chk("rst_addr", 32'(SRAM_address), 32'd0);
    chk("rst_data", 32'(SRAM_write_data), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    Resetn = 1'b1;
    idle(2);

    // Frame 1 (Q_sel=0): Y mapping, EOB fill, next block, then abort.
    start_frame(1'b0);
    for (int i = 0; i < 3; i++) send(tab[i].coeff, tab[i].eob, 1'b1, tab[i].addr, tab[i].data);
    cnt = 0;
    while (in_ready == 1'b0 && cnt < 200) begin @(posedge Clock); #1; cnt++; end
    chk("eob_fill_cycles", 32'(cnt), 32'd61);
    send(tab[3].coeff, tab[3].eob, 1'b1, tab[3].addr, tab[3].data);
    cnt = $urandom_range(1, 10);
    for (int i = 0; i < cnt; i++) send(rand_coeff(), (i == cnt - 1), 1'b0, 18'd0, 16'd0);
    for (int i = 0; i < 18; i++) send(rand_coeff(), 1'b0, 1'b0, 18'd0, 16'd0);

    // Reset in block 3 at k=17: outputs drop without waiting for a clock.
    @(negedge Clock); #1;
    Resetn = 1'b0;
    #1;
    chk("abort_we_n", 32'(SRAM_we_n), 32'd1);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete(); exp_cyc_q.delete();
    @(posedge Clock); #1;
    Resetn = 1'b1;
    idle(1);

    // Frame 2 (Q_sel=1): restart at base, saturation corner, random rest.
    start_frame(1'b1);
    send(tab[4].coeff, tab[4].eob, 1'b1, tab[4].addr, tab[4].data);
    send(tab[5].coeff, tab[5].eob, 1'b1, tab[5].addr, tab[5].data);
    rand_frame();
    end_checks();

    // Frame 3 (Q_sel=0): fully random, restarted straight after Done.
    start_frame(1'b0);
    rand_frame();
    end_checks();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coeff_dequant_writer.md
Name: coeff_dequant_writer

Overview:
- Upstream neighbour of the IDCT stage.
- Consumes the decoded coefficient stream (zigzag order, 64 per 8x8 block) and dequantizes each coefficient by a power-of-two shift.
- Writes the results into the pre-IDCT SRAM region in the block/row layout the IDCT fetch stage reads: Y from 76800, U from 153600, V from 192000, ending at 230399.
- Owns the SRAM write port while Busy.

Parameters:
- PREIDCT_BASE, 76800: SRAM word address of the Y coefficient region.
- Y_WIDTH, 320: Y row pitch in words.
- UV_WIDTH, 160: U and V row pitch in words.
- IMG_ROWS, 240: coefficient rows per plane.

Ports:
- Clock  in  1  system clock.
- Resetn  in  1  asynchronous active-low reset.
- Start  in  1  single-cycle pulse; begins a full frame (2400 blocks).
- Q_sel  in  1  quantization matrix select; sampled on accepted Start.
- in_valid  in  1  coefficient present.
- in_coeff  in  16  signed quantized coefficient.
- in_eob  in  1  end-of-block: all later coefficients of this block are zero.
- in_ready  out  1  coefficient accepted when in_valid && in_ready.
- SRAM_address  out  18  write address.
- SRAM_write_data  out  16  dequantized coefficient.
- SRAM_we_n  out  1  active-low write enable.
- Busy  out  1  high from the cycle after Start until Done.
- Done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset is decided: Resetn, asynchronous, active-low; clock Clock.
- Reset values: in_ready=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, Busy=0, Done=0. All counters 0, state IDLE.
- Reset mid-frame aborts immediately; no partial-block cleanup.
- States: IDLE, RUN, FILL, FINISH.
- IDLE:
  - Start=1 -> RUN next cycle. Clear k (0..63), block counter (0..2399). Latch Q_sel. Busy=1.
- RUN:
  - in_ready=1.
  - On handshake: compute (r,c) from the standard JPEG zigzag for index k (k0=(0,0), k1=(0,1), k2=(1,0), k3=(2,0), k4=(1,1), k5=(0,2), ..., k63=(7,7)).
  - The following cycle drives SRAM_we_n=0 with the registered address and data. Write latency is exactly 1 cycle.
  - Back-to-back handshakes give back-to-back writes.
  - Cycles without a handshake drive SRAM_we_n=1.
- In-eob handling:
  - Handshake with in_eob=1 and k<63: the coefficient is written normally, then state -> FILL.
  - in_eob at k=63 is ignored.
- FILL:
  - in_ready=0.
  - Writes 0 to positions k+1..63, one per cycle, continuing the zigzag walk.
  - After k=63 the block advances; state returns to RUN.
- Block advance:
  - After position 63, k wraps to 0 and the block counter increments.
  - Blocks 0..1199 are Y (40 across, raster order).
  - Blocks 1200..1799 are U (20 across); blocks 1800..2399 are V (20 across).
- Address:
  - address = segment_base + (brow*8+r)*pitch + bcol*8 + c.
  - Y: base 76800, pitch 320. U: base 153600, pitch 160. V: base 192000, pitch 160.
  - brow and bcol are relative to the segment.
- Dequant: data = in_coeff <<< shift, with s=r+c.
  - Q_sel=0 shift by s: 0:3, 1:2, 2:3, 3:3, 4:4, 5:4, 6:5, >=7:5.
  - Q_sel=1 shift by s: 0:3, 1:1, 2:1, 3:1, 4:2, 5:2, 6:3, >=7:3.
  - Intermediate is computed at 24-bit signed; overflow handling is set by the optional feature.
- Frame end:
  - Accepting/filling position 63 of block 2399 -> FINISH.
  - The final write issues in that cycle.
  - Done=1 for the next cycle; Busy=0 and state IDLE in that same cycle.
- Start while Busy is ignored. in_valid while in_ready=0 is not consumed.

Optional Feature:
- Macro: DEQUANT_SATURATE_EN.
- Defined: the 24-bit result saturates to 16-bit signed (max 0x7FFF, min 0x8000).
- Undefined: the low 16 bits are written (wraparound).

Test Plan:
- Y mapping: Start, Q_sel=0; coeffs 5, -3, 1 at k=0..2 -> writes (76800, 0x0028), (76801, 0xFFF4), (77120, 0x0004). Each write occurs one cycle after its handshake.
- EOB fill: in_eob with k=2 of block 0 -> in_ready low for 61 cycles, 61 zero writes ending at address 76800+7*320+7=79047. Next coeff at k=0 goes to 76808.
- Block raster/segments: block 40 k=0 -> 79360. Block 1200 k=0 -> 153600; k=2 -> 153760. Block 1800 k=0 -> 192000.
- Saturation: Q_sel=1, k=0 coeff 0x1000 -> 0x7FFF with DEQUANT_SATURATE_EN, 0x8000 without. Coeff 0xF000 -> 0x8000 in both builds.
- Frame end: after all 2400 blocks, the last write is at address 230399. Done pulses exactly once the next cycle with Busy=0. A second Start during Busy produces no effect.
- Reset mid-block (k=17, block 3): SRAM_we_n=1 and in_ready=0 immediately. A fresh Start restarts at address 76800.
